// File: rtl/canny_pipeline_sequencer_if.sv
// canny_pipeline_sequencer_if: start/abort request, per-stage enable/done and status bundle
interface canny_pipeline_sequencer_if #(
  parameter int NUM_STAGES  = 5,
  parameter int FRAME_CNT_W = 16
);
  logic                   start;
  logic                   abort;
  logic [NUM_STAGES-1:0]  stage_done;
  logic [NUM_STAGES-1:0]  stage_enable;
  logic                   busy;
  logic [2:0]             current_stage;
  logic                   frame_done;
  logic                   error;
  logic [2:0]             error_stage;
  logic [FRAME_CNT_W-1:0] frame_count;
  modport master (
    output start, abort, stage_done,
    input  stage_enable, busy, current_stage, frame_done, error, error_stage, frame_count
  );
  modport slave (
    input  start, abort, stage_done,
    output stage_enable, busy, current_stage, frame_done, error, error_stage, frame_count
  );
endinterface

// File: rtl/canny_pipeline_sequencer.sv
// canny_pipeline_sequencer: runs gaussian..hysterisis stages in order with a per-stage watchdog
module canny_pipeline_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int TIMEOUT_W   = 20,
  parameter int FRAME_CNT_W = 16
) (
  input logic clk,
  input logic reset,
  canny_pipeline_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, GAP, FIN, ERROR} state_t;
  localparam logic [2:0] LAST = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE = {{(NUM_STAGES-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_LIM = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  state_t                 state;
  logic [TIMEOUT_W-1:0]   wd;
  logic [NUM_STAGES-1:0]  en;
  logic                   busy;
  logic [2:0]             cur;
  logic                   fdone;
  logic                   err;
  logic [2:0]             err_stage;
  logic [FRAME_CNT_W-1:0] cnt;
  assign bus.stage_enable  = en;
  assign bus.busy          = busy;
  assign bus.current_stage = cur;
  assign bus.frame_done    = fdone;
  assign bus.error         = err;
  assign bus.error_stage   = err_stage;
  assign bus.frame_count   = cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wd        <= '0;
      en        <= '0;
      busy      <= 1'b0;
      cur       <= 3'd0;
      fdone     <= 1'b0;
      err       <= 1'b0;
      err_stage <= 3'd0;
      cnt       <= '0;
    end else begin
      fdone <= 1'b0;
      wd    <= '0;
      if (bus.abort) begin
        state     <= IDLE;
        en        <= '0;
        busy      <= 1'b0;
        err       <= 1'b0;
        err_stage <= 3'd0;
      end else begin
        case (state)
          IDLE, ERROR: if (bus.start) begin
            state     <= RUN;
            en        <= ONE;
            busy      <= 1'b1;
            cur       <= 3'd0;
            err       <= 1'b0;
            err_stage <= 3'd0;
          end
          RUN: begin
            // done has priority over a watchdog expiry in the same cycle
            if (bus.stage_done[cur]) begin
              en <= '0;
              if (cur == LAST) begin
                state <= FIN;
                busy  <= 1'b0;
                fdone <= 1'b1;
                cnt   <= cnt + FRAME_CNT_W'(1);
              end else begin
                state <= GAP;
              end
            end else if (wd == WD_LIM) begin
              state     <= ERROR;
              en        <= '0;
              busy      <= 1'b0;
              err       <= 1'b1;
              err_stage <= cur;
            end else begin
              wd <= wd + TIMEOUT_W'(1);
            end
          end
          GAP: begin
            state <= RUN;
            en    <= ONE << (cur + 3'd1);
            cur   <= cur + 3'd1;
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_canny_pipeline_sequencer.sv
// tb_canny_pipeline_sequencer: schedule-model check of frame sequencing, timeout, abort, wrap, reset
module tb_canny_pipeline_sequencer;
  localparam int NS = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  canny_pipeline_sequencer_if #(.NUM_STAGES(NS), .FRAME_CNT_W(2)) bus ();
  canny_pipeline_sequencer #(.NUM_STAGES(NS), .TIMEOUT_W(4), .FRAME_CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int lat [NS];
  int en_cyc [NS];
  int want [5] = '{1, 2, 3, 0, 1};
  logic [NS-1:0] stub_done = '0;
  logic [NS-1:0] force_mask = '0;
  assign bus.stage_done = stub_done | force_mask;
  // stage stubs: done is seen by the sequencer on the lat-th edge after enable rises; lat 0 = never
  always @(negedge clk)
    for (int k = 0; k < NS; k++) begin
      en_cyc[k] = bus.stage_enable[k] ? en_cyc[k] + 1 : 0;
      stub_done[k] = bus.stage_enable[k] && lat[k] != 0 && en_cyc[k] >= lat[k];
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask
  task automatic chk_all(input string tag, input int en, input int bsy, input int cur,
                         input int fd, input int er, input int es, input int cnt);
    chk({tag, ".enable"}, 32'(bus.stage_enable), en);
    chk({tag, ".busy"}, 32'(bus.busy), bsy);
    chk({tag, ".current_stage"}, 32'(bus.current_stage), cur);
    chk({tag, ".frame_done"}, 32'(bus.frame_done), fd);
    chk({tag, ".error"}, 32'(bus.error), er);
    chk({tag, ".error_stage"}, 32'(bus.error_stage), es);
    chk({tag, ".frame_count"}, 32'(bus.frame_count), cnt);
  endtask
  // Expected waveform is derived from the stage schedule: stage k is enabled for lat cycles
  // starting at s[k]; one idle cycle separates stages; frame_done falls on the last done edge.
  task automatic run_frame(input string tag, input int to, input int ab_k, input int ab_off,
                           input bit ab_st, input bit spur, input int rs_k, input int rs_off);
    int s [NS];
    int m [NS];
    int f, c_end, ab_c, rs_c, e_en, e_cur, last_cur, cnt0;
    string t;
    for (int k = 0; k < NS; k++) m[k] = (k == to) ? 15 : lat[k];
    s[0] = 0;
    for (int k = 1; k < NS; k++) s[k] = s[k-1] + m[k-1] + 1;
    f = s[NS-1] + m[NS-1];
    ab_c = ab_k >= 0 ? s[ab_k] + ab_off : -1;
    rs_c = rs_k >= 0 ? s[rs_k] + rs_off : -1;
    c_end = ab_c >= 0 ? ab_c + 2 : to >= 0 ? s[to] + 17 : rs_c >= 0 ? rs_c : f + 1;
    cnt0 = exp_cnt;
    last_cur = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c <= c_end; c++) begin
      @(negedge clk);
      t = $sformatf("%s@%0d", tag, c);
      if (ab_c >= 0 && c > ab_c) chk_all(t, 0, 0, last_cur, 0, 0, 0, cnt0);
      else if (to >= 0 && c >= s[to] + 15) chk_all(t, 0, 0, to, 0, 1, to, cnt0);
      else begin
        e_en = 0;
        e_cur = 0;
        for (int k = 0; k < NS; k++) begin
          if (s[k] <= c) e_cur = k;
          if (c >= s[k] && c < s[k] + m[k]) e_en = 1 << k;
        end
        last_cur = e_cur;
        chk_all(t, e_en, int'(c < f), e_cur, int'(c == f), 0, 0, c >= f ? (cnt0 + 1) % 4 : cnt0);
      end
      bus.start = (spur && c < f) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.abort = (c == ab_c);
      if (c == ab_c && ab_st) bus.start = 1'b1;
      force_mask = (spur && c >= s[1] && c < s[1] + m[1]) ? {1'b1, {(NS-1){1'b0}}} : '0;
      if (c == rs_c) begin
        reset = 1'b1;
        #1;
        chk_all({tag, ".async"}, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all({tag, ".held"}, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
      end
    end
    if (to < 0 && ab_k < 0 && rs_k < 0) exp_cnt = (cnt0 + 1) % 4;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int k = 0; k < NS; k++) lat[k] = 3;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    run_frame("normal", -1, -1, 0, 1'b0, 1'b0, -1, 0);
    chk("normal.count", 32'(bus.frame_count), 1);
    for (int k = 0; k < NS; k++) lat[k] = $urandom_range(1, 5);
    run_frame("spurious", -1, -1, 0, 1'b0, 1'b1, -1, 0);
    for (int k = 0; k < NS; k++) lat[k] = $urandom_range(1, 5);
    lat[2] = 0;
    run_frame("timeout", 2, -1, 0, 1'b0, 1'b0, -1, 0);
    lat[2] = $urandom_range(1, 5);
    run_frame("restart", -1, -1, 0, 1'b0, 1'b0, -1, 0);
    lat[3] = 4;
    run_frame("abort", -1, 3, 1, 1'b0, 1'b0, -1, 0);
    run_frame("abort_start", -1, 1, 0, 1'b1, 1'b0, -1, 0);
    lat[2] = 3;
    run_frame("reset_mid", -1, -1, 0, 1'b0, 1'b0, 2, 1);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NS; k++) lat[k] = $urandom_range(1, 4);
      run_frame($sformatf("wrap%0d", i), -1, -1, 0, 1'b0, 1'b0, -1, 0);
      chk($sformatf("wrap_seq%0d", i), 32'(bus.frame_count), want[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
